mdio_receptor_mm: RTL and testbench

MDIO_RECEPTOR_MM -- requirements
Module: mdio_receptor_mm

---
 rtl/mdio_pkg.sv | 42 ++++
 rtl/mdio_regfile.sv | 32 +++
 rtl/mdio_receptor_mm.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_mdio_receptor_mm.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO frame definitions: FSM states, start/opcode codes and
// field widths used by the receptor and its register file.
package mdio_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    START,
    OPCODE,
    PHYAD,
    REGAD,
    TA,
    WDATA,
    RDATA,
    SKIP
  } state_e;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP22_WR    = 2'b01;
  localparam logic [1:0] OP22_RD    = 2'b10;
  localparam logic [1:0] OP45_ADDR  = 2'b00;
  localparam logic [1:0] OP45_WR    = 2'b01;
  localparam logic [1:0] OP45_RDINC = 2'b10;
  localparam logic [1:0] OP45_RD    = 2'b11;

  localparam int OP_W     = 2;
  localparam int PHY_W    = 5;
  localparam int REG_W    = 5;
  localparam int TA_W     = 2;
  localparam int DATA_W   = 16;
  localparam int SKIP_LEN = TA_W + DATA_W;

  localparam logic [1:0] TA_WR = 2'b10;

  // Every valid read opcode (C22 10, C45 10/11) has the upper bit set.
  function automatic logic op_is_read(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdio_regfile.sv
// Register storage: one synchronous write port, asynchronous read,
// asynchronous clear.
module mdio_regfile
  import mdio_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mdio_receptor_mm.sv
// MDIO receptor: decodes Clause-22/45 frames sampled on MDC and serves
// reads and writes from a local register file.
module mdio_receptor_mm
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd7,
  parameter logic [4:0] DEV_ADDR     = 5'd1,
  parameter int         REG_DEPTH    = 32,
  parameter bit         C45_EN       = 1'b1,
  parameter int         PREAMBLE_LEN = 0,
  parameter bit         STRICT_TA    = 1'b0
) (
  input  logic        MDC,
  input  logic        RESET,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        MDIO_DONE,
  output logic [15:0] ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        ERR
);

  localparam int IW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int PW = $clog2(PREAMBLE_LEN + 1) + 1;
  localparam logic [PW-1:0] PL_V = PW'(PREAMBLE_LEN);
  localparam state_e HOME = (PREAMBLE_LEN > 0) ? PREAMBLE : IDLE;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic        c45_q, c45_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        mdio_in_q, mdio_in_d;
  logic        done_q, done_d;
  logic        stb_q, stb_d;
  logic        err_q, err_d;

  logic          rf_we;
  logic [IW-1:0] rf_waddr;
  logic [IW-1:0] rf_raddr;
  logic [15:0]   rf_rdata;

  logic [1:0]  op_v;
  logic [4:0]  regad_v;
  logic [15:0] wr_v;
  logic [15:0] cur_addr;
  logic [15:0] rd_addr_v;
  logic        match;
  logic        ta_exp;
  logic        fail;
  logic        fin;

  assign op_v      = {op_q[0], MDIO_OUT};
  assign regad_v   = {reg_q[3:0], MDIO_OUT};
  assign wr_v      = {sh_q[14:0], MDIO_OUT};
  assign cur_addr  = c45_q ? ptr_q : {11'd0, reg_q};
  assign rd_addr_v = c45_q ? ptr_q : {11'd0, regad_v};
  assign match     = (phy_q == PHY_ADDR) && (!c45_q || regad_v == DEV_ADDR);
  assign ta_exp    = cnt_q[0] ? TA_WR[0] : TA_WR[1];
  assign rf_waddr  = cur_addr[IW-1:0];
  assign rf_raddr  = rd_addr_v[IW-1:0];

  mdio_regfile #(
    .DEPTH (REG_DEPTH),
    .IW    (IW)
  ) u_rf (
    .clk   (MDC),
    .rst   (RESET),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (wr_v),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    c45_d     = c45_q;
    op_d      = op_q;
    phy_d     = phy_q;
    reg_d     = reg_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    mdio_in_d = 1'b0;
    done_d    = 1'b0;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    rf_we     = 1'b0;
    fail      = 1'b0;
    fin       = 1'b0;
    case (state_q)
      IDLE, PREAMBLE: begin
        state_d = HOME;
        if (!MDIO_OE) begin
          pre_d = '0;
        end else if (MDIO_OUT) begin
          if (pre_q != PL_V) pre_d = pre_q + PW'(1);
        end else begin
          // A 0 after enough 1s is the first start bit.
          pre_d = '0;
          if (pre_q == PL_V) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
      end
      START: begin
        if (!MDIO_OE) begin
          fail = 1'b1;
        end else if ({1'b0, MDIO_OUT} == ST_C22) begin
          c45_d   = 1'b0;
          state_d = OPCODE;
          cnt_d   = '0;
        end else if (C45_EN && {1'b0, MDIO_OUT} == ST_C45) begin
          c45_d   = 1'b1;
          state_d = OPCODE;
          cnt_d   = '0;
        end else begin
          fail = 1'b1;
        end
      end
      OPCODE: begin
        if (!MDIO_OE) begin
          fail = 1'b1;
        end else begin
          op_d = op_v;
          if (cnt_q == 5'(OP_W - 1)) begin
            if (!c45_q && op_v != OP22_WR && op_v != OP22_RD) begin
              fail = 1'b1;
            end else begin
              state_d = PHYAD;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      PHYAD: begin
        if (!MDIO_OE) begin
          fail = 1'b1;
        end else begin
          phy_d = {phy_q[3:0], MDIO_OUT};
          if (cnt_q == 5'(PHY_W - 1)) begin
            state_d = REGAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      REGAD: begin
        if (!MDIO_OE) begin
          fail = 1'b1;
        end else begin
          reg_d = regad_v;
          if (cnt_q == 5'(REG_W - 1)) begin
            cnt_d = '0;
            if (!match) begin
              state_d = SKIP;
            end else begin
              state_d = TA;
              if (op_is_read(op_q)) begin
                sh_d   = rf_rdata;
                addr_d = rd_addr_v;
              end
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      TA: begin
        if (!op_is_read(op_q) && STRICT_TA &&
            (!MDIO_OE || MDIO_OUT != ta_exp)) begin
          fail = 1'b1;
        end else if (cnt_q == 5'(TA_W - 1)) begin
          cnt_d = '0;
          if (op_is_read(op_q)) begin
            state_d   = RDATA;
            mdio_in_d = sh_q[15];
            sh_d      = {sh_q[14:0], 1'b0};
          end else begin
            state_d = WDATA;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      WDATA: begin
        if (!MDIO_OE) begin
          fail = 1'b1;
        end else begin
          sh_d = wr_v;
          if (cnt_q == 5'(DATA_W - 1)) begin
            fin = 1'b1;
            if (c45_q && op_q == OP45_ADDR) begin
              ptr_d = wr_v;
            end else begin
              rf_we  = 1'b1;
              stb_d  = 1'b1;
              wdat_d = wr_v;
              addr_d = cur_addr;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      RDATA: begin
        if (cnt_q == 5'(DATA_W - 1)) begin
          fin = 1'b1;
          if (c45_q && op_q == OP45_RDINC) ptr_d = ptr_q + 16'd1;
        end else begin
          cnt_d     = cnt_q + 5'd1;
          mdio_in_d = sh_q[15];
          sh_d      = {sh_q[14:0], 1'b0};
        end
      end
      SKIP: begin
        if (cnt_q == 5'(SKIP_LEN - 1)) begin
          state_d = HOME;
          pre_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = HOME;
    endcase
    if (fail) begin
      err_d   = 1'b1;
      state_d = HOME;
      pre_d   = '0;
    end
    if (fin) begin
      done_d  = 1'b1;
      state_d = HOME;
      pre_d   = '0;
    end
  end

  always_ff @(posedge MDC or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      c45_q     <= 1'b0;
      op_q      <= '0;
      phy_q     <= '0;
      reg_q     <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      mdio_in_q <= 1'b0;
      done_q    <= 1'b0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      c45_q     <= c45_d;
      op_q      <= op_d;
      phy_q     <= phy_d;
      reg_q     <= reg_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      mdio_in_q <= mdio_in_d;
      done_q    <= done_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  assign MDIO_IN   = mdio_in_q;
  assign MDIO_DONE = done_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wdat_q;
  assign WR_STB    = stb_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mdio_receptor_mm.sv
// Directed bench for mdio_receptor_mm: drives MDIO frames bit by bit and
// scores write strobes and read data against queued expectations.
module tb_mdio_receptor_mm;

  logic        MDC = 1'b0;
  logic        RESET;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic        MDIO_IN;
  logic        MDIO_DONE;
  logic [15:0] ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        ERR;

  int checks   = 0;
  int failures = 0;
  int n_done;
  int n_err;
  int n_in;
  logic        last_done;
  logic [15:0] rd_bits;
  logic [15:0] rd;
  logic [31:0] exp_wr[$];
  logic [31:0] obs_wr[$];
  logic [15:0] exp_rd[$];

  always #5 MDC = ~MDC;

  mdio_receptor_mm dut (
    .MDC       (MDC),
    .RESET     (RESET),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .MDIO_IN   (MDIO_IN),
    .MDIO_DONE (MDIO_DONE),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .WR_STB    (WR_STB),
    .ERR       (ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One MDC cycle: drive, let the rising edge pass, record outputs.
  task automatic tick(input logic oe, input logic b);
    MDIO_OE  = oe;
    MDIO_OUT = b;
    @(posedge MDC);
    #1;
    if (WR_STB) obs_wr.push_back({ADDR, WR_DATA});
    if (MDIO_DONE) n_done++;
    if (ERR) n_err++;
    if (MDIO_IN) n_in++;
    last_done = MDIO_DONE;
    rd_bits   = {rd_bits[14:0], MDIO_IN};
    @(negedge MDC);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
  endtask

  task automatic clr();
    n_done = 0;
    n_err  = 0;
    n_in   = 0;
    obs_wr.delete();
  endtask

  task automatic frame(input bit c45, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input int cut,
                       input bit drop, output logic [15:0] got);
    logic [1:0] st;
    bit is_rd;
    st    = c45 ? 2'b00 : 2'b01;
    is_rd = op[1];
    got   = '0;
    last_done = 1'b0;
    tick(1'b1, st[1]);
    tick(1'b1, st[0]);
    for (int i = 1; i >= 0; i--) tick(1'b1, op[i]);
    for (int i = 4; i >= 0; i--) tick(1'b1, pa[i]);
    for (int i = 4; i >= 0; i--) tick(1'b1, ra[i]);
    if (is_rd) begin
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end else begin
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == cut) begin
        if (drop) tick(1'b0, 1'b0);
        return;
      end
      if (is_rd) tick(1'b0, 1'b0);
      else tick(1'b1, wd[15-k]);
      if (k == 14) got = rd_bits;
    end
  endtask

  task automatic drain_wr(input string tag);
    chk({tag, "_stb_n"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      chk(tag, obs_wr.pop_front(), exp_wr.pop_front());
    obs_wr.delete();
    exp_wr.delete();
  endtask

  task automatic check_rd(input string tag, input logic [15:0] got);
    if (exp_rd.size() == 0) chk({tag, "_noexp"}, 32'd1, 32'd0);
    else chk(tag, {16'd0, got}, {16'd0, exp_rd.pop_front()});
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_mdio_in"}, {31'd0, MDIO_IN}, 32'd0);
    chk({tag, "_done"}, {31'd0, MDIO_DONE}, 32'd0);
    chk({tag, "_stb"}, {31'd0, WR_STB}, 32'd0);
    chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
    chk({tag, "_addr"}, {16'd0, ADDR}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, WR_DATA}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET    = 1'b1;
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b1;
    rd_bits  = '0;
    last_done = 1'b0;
    clr();
    #3;
    chk_outs_zero("rst");
    @(negedge MDC);
    @(negedge MDC);
    RESET = 1'b0;
    idle(2);

    clr();
    exp_wr.push_back({16'd21, 16'h43AE});
    frame(1'b0, 2'b01, 5'd7, 5'd21, 16'h43AE, -1, 1'b0, rd);
    chk("wr22_done_n", n_done, 1);
    chk("wr22_done_last", {31'd0, last_done}, 1);
    chk("wr22_err_n", n_err, 0);
    drain_wr("wr22");
    idle(1);

    clr();
    exp_rd.push_back(16'h43AE);
    frame(1'b0, 2'b10, 5'd7, 5'd21, 16'h0, -1, 1'b0, rd);
    check_rd("rd22_data", rd);
    chk("rd22_done_n", n_done, 1);
    chk("rd22_done_last", {31'd0, last_done}, 1);
    chk("rd22_addr", {16'd0, ADDR}, 21);
    chk("rd22_stb_n", 32'(obs_wr.size()), 0);

    clr();
    frame(1'b0, 2'b10, 5'd3, 5'd21, 16'h0, -1, 1'b0, rd);
    chk("phy3_done_n", n_done, 0);
    chk("phy3_err_n", n_err, 0);
    chk("phy3_in_n", n_in, 0);
    chk("phy3_stb_n", 32'(obs_wr.size()), 0);

    clr();
    exp_rd.push_back(16'h43AE);
    frame(1'b0, 2'b10, 5'd7, 5'd21, 16'h0, -1, 1'b0, rd);
    check_rd("phy7_after_skip", rd);
    chk("phy7_done_n", n_done, 1);

    clr();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    idle(2);
    chk("badop_err_n", n_err, 1);
    chk("badop_done_n", n_done, 0);

    clr();
    frame(1'b1, 2'b00, 5'd7, 5'd1, 16'h0005, -1, 1'b0, rd);
    chk("c45_addr_done_n", n_done, 1);
    chk("c45_addr_stb_n", 32'(obs_wr.size()), 0);

    clr();
    exp_wr.push_back({16'd5, 16'hBEEF});
    frame(1'b1, 2'b01, 5'd7, 5'd1, 16'hBEEF, -1, 1'b0, rd);
    drain_wr("wr45");

    clr();
    exp_rd.push_back(16'hBEEF);
    frame(1'b1, 2'b10, 5'd7, 5'd1, 16'h0, -1, 1'b0, rd);
    check_rd("rdinc45_data", rd);
    chk("rdinc45_addr", {16'd0, ADDR}, 5);
    chk("rdinc45_done_n", n_done, 1);

    clr();
    exp_rd.push_back(16'h0000);
    frame(1'b1, 2'b11, 5'd7, 5'd1, 16'h0, -1, 1'b0, rd);
    check_rd("rd45_p6_data", rd);
    chk("rd45_p6_addr", {16'd0, ADDR}, 6);

    clr();
    frame(1'b1, 2'b11, 5'd7, 5'd2, 16'h0, -1, 1'b0, rd);
    chk("devad_done_n", n_done, 0);
    chk("devad_in_n", n_in, 0);
    chk("devad_err_n", n_err, 0);

    clr();
    frame(1'b0, 2'b01, 5'd7, 5'd21, 16'h5555, 8, 1'b1, rd);
    idle(2);
    chk("oedrop_err_n", n_err, 1);
    chk("oedrop_done_n", n_done, 0);
    chk("oedrop_stb_n", 32'(obs_wr.size()), 0);

    clr();
    exp_rd.push_back(16'h43AE);
    frame(1'b0, 2'b10, 5'd7, 5'd21, 16'h0, -1, 1'b0, rd);
    check_rd("oedrop_reg_kept", rd);

    clr();
    frame(1'b0, 2'b01, 5'd7, 5'd10, 16'h1234, 6, 1'b0, rd);
    RESET = 1'b1;
    #2;
    chk_outs_zero("midrst");
    @(negedge MDC);
    RESET = 1'b0;
    idle(2);
    chk("midrst_stb_n", 32'(obs_wr.size()), 0);

    clr();
    exp_rd.push_back(16'h0000);
    frame(1'b0, 2'b10, 5'd7, 5'd21, 16'h0, -1, 1'b0, rd);
    check_rd("midrst_cleared", rd);

    clr();
    exp_wr.push_back({16'd10, 16'h1234});
    frame(1'b0, 2'b01, 5'd7, 5'd10, 16'h1234, -1, 1'b0, rd);
    drain_wr("post_rst_wr");

    clr();
    exp_rd.push_back(16'h1234);
    frame(1'b0, 2'b10, 5'd7, 5'd10, 16'h0, -1, 1'b0, rd);
    check_rd("b2b_rd_new", rd);
    chk("b2b_done_n", n_done, 1);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
